display_scan: RTL

Multiplexed seven-segment display driver that consumes the slow square wave from the ripple clock divider. It synchronizes that wave into the system clock domain and detects its rising edges. On each edge it advances to the next digit, driving active-low anode and segment lines from a frame-coherent snapshot of a hex value. It sits between the clock divider and the board's 7-segment pins.

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scan_if.sv | 27 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/display_scan.sv | 101 ++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment driver: blank pattern,
// active-low hex segment table and default digit count.
package display_pkg;

    localparam int DEFAULT_N_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a; entry n decodes nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/display_scan_if.sv
// Pin-side bundle of the seven-segment scanner: divider input, display data
// from the host and the active-low digit/segment outputs.
interface display_scan_if
    import display_pkg::*;
#(
    parameter int N_DIGITS = DEFAULT_N_DIGITS
);

    logic                    scan_in;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp;
    logic [N_DIGITS-1:0]     an;
    logic [6:0]              seg;
    logic                    seg_dp;
    logic                    frame_start;

    modport master (
        output scan_in, value, dp,
        input  an, seg, seg_dp, frame_start
    );

    modport slave (
        input  scan_in, value, dp,
        output an, seg, seg_dp, frame_start
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scan.sv
// Multiplexed seven-segment scanner stepped by rising edges of a slow divider
// wave. Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
module display_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS    = DEFAULT_N_DIGITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    display_scan_if.slave bus
);

    localparam int IW = $clog2(N_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

    logic [SYNC_STAGES-1:0]  sync;
    logic                    prev;
    logic                    step;
    logic                    wrap;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic [4*N_DIGITS-1:0]   shadow;
    logic [4*N_DIGITS-1:0]   src;
    logic [N_DIGITS-1:0]     dp_shadow;
    logic [N_DIGITS-1:0]     dp_src;
    logic [3:0]              nibble;
    logic [6:0]              digit_seg;
    logic [6:0]              seg_next;
    logic [N_DIGITS-1:0]     an_next;
    logic                    lz_blank;

    logic [N_DIGITS-1:0]     an_r;
    logic [6:0]              seg_r;
    logic                    seg_dp_r;
    logic                    frame_start_r;

    assign step = sync[SYNC_STAGES-1] & ~prev;

    // On wrap the frame restarts from the incoming value, so digit 0 is never stale.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wrap     = (idx == LAST_IDX);
        idx_next = wrap ? '0 : idx + IW'(1);
        src      = wrap ? bus.value : shadow;
        dp_src   = wrap ? bus.dp : dp_shadow;
        nibble   = src[4*int'(idx_next) +: 4];
        an_next  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_next);
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = (idx_next != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx_next) && src[4*i +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
`endif
        seg_next = lz_blank ? SEG_BLANK : digit_seg;
    end

    hex_to_7seg u_dec (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: shadow registers are cleared too, since reset fully defines the frame state.
            sync          <= '0;
            prev          <= 1'b0;
            idx           <= LAST_IDX;
            shadow        <= '0;
            dp_shadow     <= '0;
            an_r          <= '1;
            seg_r         <= SEG_BLANK;
            seg_dp_r      <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let the synchronizer shift one stage per clock.
            sync          <= {sync[SYNC_STAGES-2:0], bus.scan_in};
            prev          <= sync[SYNC_STAGES-1];
            frame_start_r <= step & wrap;
            if (step) begin
                idx      <= idx_next;
                an_r     <= an_next;
                seg_r    <= seg_next;
                seg_dp_r <= ~dp_src[idx_next];
                if (wrap) begin
                    shadow    <= bus.value;
                    dp_shadow <= bus.dp;
                end
            end
        end
    end

    assign bus.an          = an_r;
    assign bus.seg         = seg_r;
    assign bus.seg_dp      = seg_dp_r;
    assign bus.frame_start = frame_start_r;

endmodule
